// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// program_loader_pkg : state encoding and shared constants for the boot loader
// Revision: 1.0
// ============================================================================
package program_loader_pkg;

    localparam int INST_W     = 16;
    localparam int IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// program_loader_if : byte stream in, instruction-memory write port out
// Revision: 1.0
// ============================================================================
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    import program_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    // slave = the loader; master = the byte source / memory side
    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : assembles a framed byte stream into 16-bit instructions,
//                  verifies the XOR checksum and releases the core on success
// Revision: 1.0
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 1024,
    parameter int AUTO_START = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start,
    program_loader_if.slave   bus,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int                IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    logic [8:0]        count_q;
    logic [8:0]        widx_q;
    logic [7:0]        hi_q;
    logic [7:0]        xor_q;
    logic [IDLE_W-1:0] idle_q;

    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [INST_W-1:0] imem_wdata_q;
    logic              core_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        err_code_q;

    logic accept;
    logic in_frame;
    logic timeout_hit;
    logic start_ok;

    assign accept      = bus.in_valid & in_ready_q;
    assign in_frame    = (state_q == S_LEN) || (state_q == S_HI) ||
                         (state_q == S_LO)  || (state_q == S_CSUM);
    assign timeout_hit = (TIMEOUT != 0) && in_frame && !accept && (idle_q == TO_LAST);
    // IDLE is only reachable from reset, so AUTO_START acts as a one-shot start
    assign start_ok    = start || ((state_q == S_IDLE) && (AUTO_START != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            widx_q       <= '0;
            hi_q         <= '0;
            xor_q        <= '0;
            idle_q       <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            imem_we_q <= 1'b0;

            if (accept) begin
                idle_q <= '0;
            end else if (in_frame) begin
                idle_q <= idle_q + 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        state_q    <= S_LEN;
                        idle_q     <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        count_q <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        widx_q  <= '0;
                        xor_q   <= bus.in_data;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_q    <= bus.in_data;
                        xor_q   <= xor_q ^ bus.in_data;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        xor_q        <= xor_q ^ bus.in_data;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= ADDR_W'(widx_q);
                        imem_wdata_q <= {hi_q, bus.in_data};
                        widx_q       <= widx_q + 9'd1;
                        state_q      <= (widx_q == count_q - 9'd1) ? S_CSUM : S_HI;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.in_data == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (timeout_hit) begin
                state_q    <= S_ERR;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_rst       = core_rst_q | rst;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;

endmodule
`default_nettype wire
